// File: rtl/sum_accum.sv
// sum_accum: collects a block of upstream adder sums and accumulates them into a
// saturating total. It also counts the zero-flagged samples in the block and
// presents one result per block through a valid/ready handshake.
module sum_accum #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_sum,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [LEN_W:0]   out_zero_cnt,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W:0] ONE_CNT = {{LEN_W{1'b0}}, 1'b1};

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   blk_len;
    logic [LEN_W:0]   zero_cnt;
    logic             sat;

    logic             accept;
    logic [LEN_W:0]   len_ext;
    logic [ACC_W-1:0] in_sum_ext;
    logic [ACC_W:0]   sum_wide;
    logic             sat_now;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W:0]   cnt_next;
    logic [LEN_W:0]   zero_next;

    // Next-value datapath: a len of 0 maps onto 2^LEN_W simply by prepending the
    // "is zero" bit, and the add is one bit wider so its carry flags saturation.
    always_comb begin
        accept     = in_valid && in_ready;
        len_ext    = {(len == '0), len};
        in_sum_ext = {{(ACC_W-9){1'b0}}, in_sum};
        sum_wide   = {1'b0, acc} + {1'b0, in_sum_ext};
        sat_now    = sum_wide[ACC_W];
        acc_next   = sat_now ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        cnt_next   = cnt + ONE_CNT;
        zero_next  = zero_cnt + {{LEN_W{1'b0}}, in_zero};
    end

    // Block control FSM with registered handshake and result outputs; clear
    // beats every other event and drops any sample offered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_zero_cnt <= '0;
            out_sat      <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            blk_len      <= '0;
            zero_cnt     <= '0;
            sat          <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_zero_cnt <= '0;
            out_sat      <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            blk_len      <= '0;
            zero_cnt     <= '0;
            sat          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        blk_len  <= len_ext;
                        acc      <= in_sum_ext;
                        cnt      <= ONE_CNT;
                        zero_cnt <= {{LEN_W{1'b0}}, in_zero};
                        sat      <= 1'b0;
                        if (len_ext == ONE_CNT) begin
                            state        <= HOLD;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_acc      <= in_sum_ext;
                            out_zero_cnt <= {{LEN_W{1'b0}}, in_zero};
                            out_sat      <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc      <= acc_next;
                        cnt      <= cnt_next;
                        zero_cnt <= zero_next;
                        sat      <= sat | sat_now;
                        if (cnt_next == blk_len) begin
                            state        <= HOLD;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_acc      <= acc_next;
                            out_zero_cnt <= zero_next;
                            out_sat      <= sat | sat_now;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        out_valid    <= 1'b0;
                        out_acc      <= '0;
                        out_zero_cnt <= '0;
                        out_sat      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: drives sum_accum through its block scenarios. A behavioural
// model queues the expected result of each block as its last sample is accepted,
// and each scenario pops and compares that result when out_valid appears.
module tb_sum_accum;

    localparam int ACC_W   = 10;
    localparam int LEN_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_sum;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [LEN_W:0]   out_zero_cnt;
    logic             out_sat;

    typedef struct {
        int acc;
        int zc;
        bit sat;
    } res_t;

    res_t sb[$];
    res_t exp_r;

    int checks = 0;
    int errors = 0;

    int m_len = 0;
    int m_cnt = 0;
    int m_acc = 0;
    int m_zc  = 0;
    bit m_sat = 0;

    sum_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .len          (len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_zero      (in_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_zero_cnt (out_zero_cnt),
        .out_sat      (out_sat)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges in a way its own bounds missed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model a block start being discarded (clear or reset).
    task automatic model_clear();
        m_cnt = 0;
        m_acc = 0;
        m_zc  = 0;
        m_sat = 0;
    endtask

    // Model one accepted sample; queues the expected result on the block's last sample.
    task automatic model_add(input int s, input int z, input int l);
        res_t r;
        if (m_cnt == 0) begin
            m_len = (l == 0) ? (1 << LEN_W) : l;
            m_acc = 0;
            m_zc  = 0;
            m_sat = 0;
        end
        m_acc = m_acc + s;
        if (m_acc > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_sat = 1;
        end
        m_zc  = m_zc + z;
        m_cnt = m_cnt + 1;
        if (m_cnt == m_len) begin
            r.acc = m_acc;
            r.zc  = m_zc;
            r.sat = m_sat;
            sb.push_back(r);
            m_cnt = 0;
        end
    endtask

    // Offer one sample from a falling edge and wait until it is accepted; returns
    // on the falling edge after the accepting rising edge with in_valid still high.
    task automatic applyStimulus(input int s, input bit z);
        int guard;
        int l_used;
        guard    = 0;
        in_valid = 1'b1;
        in_sum   = s[8:0];
        in_zero  = z;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
        end else begin
            l_used = int'(len);
            @(negedge clk);
            model_add(s, int'(z), l_used);
        end
    endtask

    // Pop the next expected result; an empty scoreboard counts against the run.
    task automatic pop_expected(output res_t r);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: size=0 required >0");
            r.acc = -1;
            r.zc  = -1;
            r.sat = 0;
        end else begin
            r = sb.pop_front();
        end
    endtask

    // Reset values while rst_n is held low.
    task automatic test_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        len       = 4'd3;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_zero   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
        checks++;
        if (out_acc !== '0) begin errors++; $display("[TB] FAIL reset_out_acc: got %0d required 0", out_acc); end
        checks++;
        if (out_zero_cnt !== '0 || out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: zero_cnt=%0d sat=%0b required 0 0", out_zero_cnt, out_sat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    // Three back-to-back samples, one of them zero-flagged, with a one-cycle HOLD.
    task automatic test_basic();
        len       = 4'd3;
        out_ready = 1'b1;
        applyStimulus(10, 1'b0);
        applyStimulus(0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %0b required 0", out_valid); end
        applyStimulus(255, 1'b0);
        in_valid = 1'b0;
        pop_expected(exp_r);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: out_valid=%0b required 1", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_ready: in_ready=%0b required 0", in_ready); end
        checks++;
        if (int'(out_acc) !== exp_r.acc || int'(out_zero_cnt) !== exp_r.zc || out_sat !== exp_r.sat) begin
            errors++;
            $display("[TB] FAIL basic_result: acc=%0d zc=%0d sat=%0b required %0d %0d %0b",
                     out_acc, out_zero_cnt, out_sat, exp_r.acc, exp_r.zc, exp_r.sat);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    // Sixteen samples of 100 overflow a 10-bit accumulator and must clamp.
    task automatic test_saturation();
        len       = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(100, 1'b0);
        in_valid = 1'b0;
        pop_expected(exp_r);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sat_valid: got %0b required 1", out_valid); end
        checks++;
        if (int'(out_acc) !== exp_r.acc || out_sat !== exp_r.sat || int'(out_zero_cnt) !== exp_r.zc) begin
            errors++;
            $display("[TB] FAIL sat_result: acc=%0d sat=%0b zc=%0d required %0d %0b %0d",
                     out_acc, out_sat, out_zero_cnt, exp_r.acc, exp_r.sat, exp_r.zc);
        end
        @(negedge clk);
    endtask

    // Full-length block of zero samples: the zero count reaches 16 without wrapping.
    task automatic test_zero_count_full();
        len       = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1);
        in_valid = 1'b0;
        pop_expected(exp_r);
        checks++;
        if (out_valid !== 1'b1 || int'(out_zero_cnt) !== exp_r.zc || int'(out_acc) !== exp_r.acc || out_sat !== exp_r.sat) begin
            errors++;
            $display("[TB] FAIL zero_cnt_full: valid=%0b zc=%0d acc=%0d sat=%0b required 1 %0d %0d %0b",
                     out_valid, out_zero_cnt, out_acc, out_sat, exp_r.zc, exp_r.acc, exp_r.sat);
        end
        @(negedge clk);
    endtask

    // Single-sample block held by downstream for five cycles; upstream stays blocked.
    task automatic test_backpressure();
        int high_cycles;
        len       = 4'd1;
        out_ready = 1'b0;
        applyStimulus(7, 1'b0);
        in_sum = 9'd99;
        pop_expected(exp_r);
        high_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid === 1'b1) high_cycles++;
            checks++;
            if (in_ready !== 1'b0 || int'(out_acc) !== exp_r.acc) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: in_ready=%0b acc=%0d required 0 %0d", i, in_ready, out_acc, exp_r.acc);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (out_valid === 1'b1) high_cycles++;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (high_cycles !== 6) begin errors++; $display("[TB] FAIL bp_valid_cycles: got %0d required 6", high_cycles); end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    // Clear mid-block drops the partial sum and the sample presented with it.
    task automatic test_clear();
        len       = 4'd4;
        out_ready = 1'b1;
        applyStimulus(50, 1'b1);
        applyStimulus(60, 1'b0);
        in_sum = 9'd200;
        clear  = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0 || out_zero_cnt !== '0 || out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_state: valid=%0b ready=%0b acc=%0d zc=%0d sat=%0b required 0 1 0 0 0",
                     out_valid, in_ready, out_acc, out_zero_cnt, out_sat);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0);
        in_valid = 1'b0;
        pop_expected(exp_r);
        checks++;
        if (out_valid !== 1'b1 || int'(out_acc) !== exp_r.acc || int'(out_zero_cnt) !== exp_r.zc) begin
            errors++;
            $display("[TB] FAIL clear_next_block: valid=%0b acc=%0d zc=%0d required 1 %0d %0d",
                     out_valid, out_acc, out_zero_cnt, exp_r.acc, exp_r.zc);
        end
        @(negedge clk);
    endtask

    // Clear while a result is pending empties the output.
    task automatic test_clear_hold();
        len       = 4'd1;
        out_ready = 1'b0;
        applyStimulus(9, 1'b1);
        in_valid = 1'b0;
        pop_expected(exp_r);
        clear = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 || out_zero_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_hold: valid=%0b acc=%0d zc=%0d ready=%0b required 0 0 0 1",
                     out_valid, out_acc, out_zero_cnt, in_ready);
        end
    endtask

    // Random in_valid gaps with len changed after the first accept.
    task automatic test_random_valid();
        int  n_acc;
        bit  done;
        bit  accepted;
        int  s_drv;
        int  z_drv;
        int  l_drv;
        len       = 4'd2;
        out_ready = 1'b1;
        n_acc     = 0;
        done      = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            s_drv    = int'($urandom_range(0, 511));
            z_drv    = int'($urandom_range(0, 1));
            in_sum   = s_drv[8:0];
            in_zero  = z_drv[0];
            l_drv    = int'(len);
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) begin
                model_add(s_drv, z_drv, l_drv);
                n_acc++;
                len = 4'd7;
            end
            if (out_valid === 1'b1) done = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done || n_acc !== 2) begin
            errors++;
            $display("[TB] FAIL rand_accepts: done=%0b accepts=%0d required 1 2", done, n_acc);
        end
        pop_expected(exp_r);
        checks++;
        if (int'(out_acc) !== exp_r.acc || int'(out_zero_cnt) !== exp_r.zc) begin
            errors++;
            $display("[TB] FAIL rand_result: acc=%0d zc=%0d required %0d %0d", out_acc, out_zero_cnt, exp_r.acc, exp_r.zc);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset while a result is pending, then a fresh block.
    task automatic test_reset_hold();
        len       = 4'd1;
        out_ready = 1'b0;
        applyStimulus(33, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%0b ready=%0b acc=%0d required 0 1 0", out_valid, in_ready, out_acc);
        end
        sb.delete();
        model_clear();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(5, 1'b0);
        in_valid = 1'b0;
        pop_expected(exp_r);
        checks++;
        if (out_valid !== 1'b1 || int'(out_acc) !== exp_r.acc) begin
            errors++;
            $display("[TB] FAIL post_reset_block: valid=%0b acc=%0d required 1 %0d", out_valid, out_acc, exp_r.acc);
        end
        @(negedge clk);
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_zero_count_full();
        test_backpressure();
        test_clear();
        test_clear_hold();
        test_random_valid();
        test_reset_hold();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: size=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
